// File: rtl/alu_seq_ctrl_if.sv
// Command/result bundle between the ALU top level and the operation sequencer.
interface alu_seq_ctrl_if #(
  parameter int W = 8
);
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] res;
  logic           dz;

  // ALU top level issues commands and collects results
  modport master (
    output start, op, x, y,
    input  busy, done, res, dz
  );

  // Sequencer accepts commands and returns results
  modport slave (
    input  start, op, x, y,
    output busy, done, res, dz
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle operation sequencer driving the ALU's shared 18-bit adder.
// ADD/SUB take one pass through the adder, MUL runs Booth radix-2, DIV runs
// unsigned non-restoring division with a final remainder correction.
//
//   state | meaning
//   IDLE  | waiting for start; adder inputs parked at zero
//   RUN   | one adder pass per cycle (1 for ADD/SUB, ITER for MUL/DIV)
//   CORR  | DIV only: add divisor back to a negative remainder
//   DONE  | done pulse, result valid; returns to IDLE
module alu_seq_ctrl #(
  parameter int W    = 8,
  parameter int ITER = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_seq_ctrl_if.slave       cmd,
  output logic [17:0]         add_op1,
  output logic [17:0]         add_op2,
  output logic                add_s,
  input  logic [17:0]         add_res
);

  localparam int AW = 18;
  localparam int RW = W + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CORR, S_DONE} state_t;

  state_t         state;
  logic [1:0]     op_r;
  logic [W-1:0]   x_r;      // ADD/SUB operand 1, MUL multiplicand M
  logic [W-1:0]   y_r;      // ADD/SUB operand 2, DIV divisor D
  logic [RW-1:0]  a_r;      // MUL accumulator A, DIV partial remainder R
  logic [W-1:0]   q_r;      // MUL multiplier / DIV quotient shift register
  logic           q1_r;     // Booth q_-1
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] res_r;
  logic           dz_r;
  logic           done_r;
  logic           busy_r;

  logic [RW-1:0]  r_shl;
  logic [RW-1:0]  sum_r;
  logic [RW-1:0]  a_mul_nxt;
  logic [W-1:0]   q_mul_nxt;
  logic [W-1:0]   q_div_nxt;
  logic           last_iter;
  logic           unused_add_hi;

  assign cmd.res  = res_r;
  assign cmd.dz   = dz_r;
  assign cmd.done = done_r;
  assign cmd.busy = busy_r;

  // DIV shifts {R,Q} left before the adder pass; the shifted R feeds op1
  assign r_shl     = {a_r[RW-2:0], q_r[W-1]};
  assign sum_r     = add_res[RW-1:0];
  assign a_mul_nxt = {sum_r[RW-1], sum_r[RW-1:1]};
  assign q_mul_nxt = {sum_r[0], q_r[W-1:1]};
  assign q_div_nxt = {q_r[W-2:0], ~sum_r[RW-1]};
  assign last_iter = (cnt == CW'(ITER - 1));

  // Adder bits above the 16-bit result are never consumed
  assign unused_add_hi = ^add_res[AW-1:2*W];

  function automatic logic [AW-1:0] sext_r(input logic [RW-1:0] v);
    return {{(AW-RW){v[RW-1]}}, v};
  endfunction

  function automatic logic [AW-1:0] sext_w(input logic [W-1:0] v);
    return {{(AW-W){v[W-1]}}, v};
  endfunction

  function automatic logic [AW-1:0] zext_w(input logic [W-1:0] v);
    return {{(AW-W){1'b0}}, v};
  endfunction

  // Adder operand steering from the current state and datapath registers
  always_comb begin
    add_op1 = '0;
    add_op2 = '0;
    add_s   = 1'b0;
    case (state)
      S_RUN: begin
        case (op_r)
          OP_ADD, OP_SUB: begin
            add_op1 = sext_w(x_r);
            add_op2 = sext_w(y_r);
            add_s   = op_r[0];
          end
          OP_MUL: begin
            add_op1 = sext_r(a_r);
            case ({q_r[0], q1_r})
              2'b01: begin
                add_op2 = sext_w(x_r);
                add_s   = 1'b0;
              end
              2'b10: begin
                add_op2 = sext_w(x_r);
                add_s   = 1'b1;
              end
              default: begin
                add_op2 = '0;
                add_s   = 1'b0;
              end
            endcase
          end
          default: begin
            // non-negative remainder subtracts the divisor, negative adds it
            add_op1 = sext_r(r_shl);
            add_op2 = zext_w(y_r);
            add_s   = ~a_r[RW-1];
          end
        endcase
      end
      S_CORR: begin
        add_op1 = sext_r(a_r);
        add_op2 = zext_w(y_r);
        add_s   = 1'b0;
      end
      default: begin
        add_op1 = '0;
        add_op2 = '0;
        add_s   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, result and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_r   <= '0;
      x_r    <= '0;
      y_r    <= '0;
      a_r    <= '0;
      q_r    <= '0;
      q1_r   <= 1'b0;
      cnt    <= '0;
      res_r  <= '0;
      dz_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.start) begin
            op_r   <= cmd.op;
            x_r    <= cmd.x;
            y_r    <= cmd.y;
            a_r    <= '0;
            q_r    <= (cmd.op == OP_DIV) ? cmd.x : cmd.y;
            q1_r   <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            if (cmd.op == OP_DIV && cmd.y == '0) begin
              res_r  <= {cmd.x, {W{1'b1}}};
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= S_DONE;
            end else begin
              dz_r  <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          case (op_r)
            OP_ADD, OP_SUB: begin
              res_r  <= add_res[2*W-1:0];
              done_r <= 1'b1;
              state  <= S_DONE;
            end
            OP_MUL: begin
              a_r  <= a_mul_nxt;
              q_r  <= q_mul_nxt;
              q1_r <= q_r[0];
              cnt  <= cnt + 1'b1;
              if (last_iter) begin
                res_r  <= {a_mul_nxt[W-1:0], q_mul_nxt};
                done_r <= 1'b1;
                state  <= S_DONE;
              end
            end
            default: begin
              a_r <= sum_r;
              q_r <= q_div_nxt;
              cnt <= cnt + 1'b1;
              if (last_iter) begin
                if (sum_r[RW-1]) begin
                  state <= S_CORR;
                end else begin
                  res_r  <= {sum_r[W-1:0], q_div_nxt};
                  done_r <= 1'b1;
                  state  <= S_DONE;
                end
              end
            end
          endcase
        end
        S_CORR: begin
          res_r  <= {add_res[W-1:0], q_r};
          done_r <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural adder in the loop.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [17:0] add_op1;
  logic [17:0] add_op2;
  logic        add_s;
  logic [17:0] add_res;

  int n_checks = 0;
  int n_errors = 0;
  logic s_log [0:31];

  alu_seq_ctrl_if #(.W(8)) bus ();

  alu_seq_ctrl #(.W(8), .ITER(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus),
    .add_op1 (add_op1),
    .add_op2 (add_op2),
    .add_s   (add_s),
    .add_res (add_res)
  );

  // External combinational adder/subtractor
  assign add_res = add_s ? (add_op1 - add_op2) : (add_op1 + add_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Issue one command, measure latency from the accept edge, check result
  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] er, input logic edz,
                        input int elat);
    int lat;
    logic got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 20) begin
      s_log[lat] = add_s;
      if (bus.done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_res"}, 32'(bus.res), 32'(er));
    check({tag, "_dz"}, 32'(bus.dz), 32'(edz));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_res_held"}, 32'(bus.res), 32'(er));
  endtask

  initial begin
    int ndone;
    logic prev_done;
    logic dbl;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.x     = 8'h00;
    bus.y     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    check("rst_add_op1", 32'(add_op1), 32'd0);
    check("rst_add_op2", 32'(add_op2), 32'd0);
    check("rst_add_s", 32'(add_s), 32'd0);
    rst_n = 1'b1;

    run_op("add_100_100", 2'b00, 8'd100, 8'd100, 16'h00C8, 1'b0, 2);
    run_op("sub_m128_1", 2'b01, 8'h80, 8'h01, 16'hFF7F, 1'b0, 2);
    check("idle_add_op1", 32'(add_op1), 32'd0);
    check("idle_add_s", 32'(add_s), 32'd0);

    run_op("mul_m3_5", 2'b10, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 9);
    run_op("mul_127_m128", 2'b10, 8'h7F, 8'h80, 16'hC080, 1'b0, 9);
    run_op("mul_m128_m128", 2'b10, 8'h80, 8'h80, 16'h4000, 1'b0, 9);

    run_op("div_200_7", 2'b11, 8'd200, 8'd7, 16'h041C, 1'b0, 10);
    run_op("div_255_1", 2'b11, 8'd255, 8'd1, 16'h00FF, 1'b0, 9);
    run_op("div_5_9", 2'b11, 8'd5, 8'd9, 16'h0500, 1'b0, 10);
    // R before each step: 0,-9,-9,-9,-9,-9,-8,-7 then correction adds
    check("div_5_9_s_it0", 32'(s_log[1]), 32'd1);
    check("div_5_9_s_it1", 32'(s_log[2]), 32'd0);
    check("div_5_9_s_it5", 32'(s_log[6]), 32'd0);
    check("div_5_9_s_it7", 32'(s_log[8]), 32'd0);
    check("div_5_9_s_corr", 32'(s_log[9]), 32'd0);

    run_op("div_42_0", 2'b11, 8'd42, 8'd0, 16'h2AFF, 1'b1, 1);
    run_op("add_clears_dz", 2'b00, 8'd5, 8'hF9, 16'hFFFE, 1'b0, 2);

    // start toggled and operands scrambled while a MUL runs
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.x     = 8'hFD;
    bus.y     = 8'h05;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k < 9) begin
        check("hold_busy_run", 32'(bus.busy), 32'd1);
        check("hold_no_early_done", 32'(bus.done), 32'd0);
        bus.start = k[0];
        bus.op    = 2'($urandom_range(0, 3));
        bus.x     = 8'($urandom);
        bus.y     = 8'($urandom);
      end else begin
        check("hold_done", 32'(bus.done), 32'd1);
        check("hold_res", 32'(bus.res), 32'h0000FFF1);
        bus.start = 1'b1;
      end
    end
    @(negedge clk);
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    check("idle_after_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;

    // start held high: one operation per IDLE visit
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.x     = 8'd1;
    bus.y     = 8'd1;
    ndone     = 0;
    prev_done = 1'b0;
    dbl       = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.done && prev_done) dbl = 1'b1;
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd3);
    check("held_no_double_done", 32'(dbl), 32'd0);
    check("held_res", 32'(bus.res), 32'h00000002);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.x     = 8'hFD;
    bus.y     = 8'h05;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_res", 32'(bus.res), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_add_op1", 32'(add_op1), 32'd0);
    check("mid_rst_add_s", 32'(add_s), 32'd0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    check("idle_after_rst", 32'(bus.busy), 32'd0);
    run_op("add_1_2_after_rst", 2'b00, 8'd1, 8'd2, 16'h0003, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
